// File: rtl/pin_conditioner.sv
// Synchronizes, debounces and edge-detects raw board pins, and reports the edges through a valid/ready event mask.
// Pin latency is SYNC_STAGES+DEBOUNCE_CYCLES-1 edges; pending events are held until acknowledged, and a repeat event on a held bit sets overflow.
module pin_conditioner #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_pins,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  output logic [WIDTH-1:0] pins_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_data,
  output logic             evt_overflow,
  output logic             irq
);

  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] new_evt;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_next;
  logic [7:0]       cnt      [WIDTH];
  logic [7:0]       cnt_next [WIDTH];
  logic             overflow;
  logic             overflow_next;
  logic             handshake;

  assign synced = sync_q[SYNC_STAGES-1];

  // A bit is accepted on the edge its counter has already seen DEBOUNCE_CYCLES-1 differing cycles.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = 8'd0;
      if (synced[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          accept[i] = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + 8'd1;
        end
      end
    end
  end

  assign new_evt   = accept & ((synced & rise_en) | (~synced & fall_en));
  assign handshake = evt_valid & evt_ready;

  // New events win over a same-edge acknowledge; overflow only counts losses on un-acknowledged bits.
  assign pending_next  = (handshake ? '0 : pending) | new_evt;
  assign overflow_next = handshake ? 1'b0 : (overflow | (|(new_evt & pending)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      stable   <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= 8'd0;
      end
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], input_pins};
      stable   <= stable ^ accept;
      pending  <= pending_next;
      overflow <= overflow_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign pins_out     = stable;
  assign evt_data     = pending;
  assign evt_valid    = |pending;
  assign evt_overflow = overflow;
  assign irq          = evt_valid | overflow;

endmodule

// File: tb/tb_pin_conditioner.sv
// Directed bench for pin_conditioner at default parameters: latency, glitch rejection, event handshake, overflow, reset.
module tb_pin_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] input_pins = 8'h00;
  logic [7:0] rise_en = 8'h00;
  logic [7:0] fall_en = 8'h00;
  logic       evt_ready = 1'b0;
  logic [7:0] pins_out;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic       evt_overflow;
  logic       irq;

  int checks = 0;
  int failures = 0;

  pin_conditioner dut (
    .clk          (clk),
    .rst          (rst),
    .input_pins   (input_pins),
    .rise_en      (rise_en),
    .fall_en      (fall_en),
    .pins_out     (pins_out),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_data     (evt_data),
    .evt_overflow (evt_overflow),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted with pins high and no clock edge yet.
    #1;
    rst = 1'b1;
    input_pins = 8'hFF;
    #1;
    check("rst_pins_out", 32'(pins_out), 32'h00);
    check("rst_evt_valid", 32'(evt_valid), 32'h0);
    check("rst_evt_data", 32'(evt_data), 32'h00);
    check("rst_overflow", 32'(evt_overflow), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // Pins high across reset release debounce up from zero.
    rise_en = 8'h80;
    tick();
    tick();
    rst = 1'b0;
    tick();
    repeat (4) tick();
    check("rel_pins_before", 32'(pins_out), 32'h00);
    tick();
    check("rel_pins_after", 32'(pins_out), 32'hFF);
    check("rel_evt_data", 32'(evt_data), 32'h80);
    check("rel_irq", 32'(irq), 32'h1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("rel_ack_valid", 32'(evt_valid), 32'h0);
    input_pins = 8'h00;
    rise_en = 8'h00;
    repeat (8) tick();
    check("fall_no_evt_pins", 32'(pins_out), 32'h00);
    check("fall_no_evt_valid", 32'(evt_valid), 32'h0);

    // Bit0 rise: exactly five edges from the sampling edge.
    rise_en = 8'h01;
    input_pins = 8'h01;
    tick();
    repeat (4) tick();
    check("lat_pins_edge4", 32'(pins_out), 32'h00);
    check("lat_valid_edge4", 32'(evt_valid), 32'h0);
    tick();
    check("lat_pins_edge5", 32'(pins_out), 32'h01);
    check("lat_data_edge5", 32'(evt_data), 32'h01);
    check("lat_valid_edge5", 32'(evt_valid), 32'h1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("lat_ack_valid", 32'(evt_valid), 32'h0);

    // Three-cycle glitch on bit1 is rejected.
    rise_en = 8'h03;
    input_pins = 8'h03;
    repeat (3) tick();
    input_pins = 8'h01;
    repeat (8) tick();
    check("glitch_pins", 32'(pins_out), 32'h01);
    check("glitch_valid", 32'(evt_valid), 32'h0);

    // Four-cycle pulse on bit1 is just long enough to be accepted.
    input_pins = 8'h03;
    repeat (4) tick();
    input_pins = 8'h01;
    repeat (10) tick();
    check("pulse4_pins", 32'(pins_out), 32'h01);
    check("pulse4_data", 32'(evt_data), 32'h02);
    check("pulse4_overflow", 32'(evt_overflow), 32'h0);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;

    // Bit2 rise then fall without acknowledge: overflow.
    rise_en = 8'h04;
    fall_en = 8'h04;
    input_pins = 8'h05;
    repeat (8) tick();
    check("ovf_rise_pins", 32'(pins_out), 32'h05);
    check("ovf_rise_data", 32'(evt_data), 32'h04);
    check("ovf_rise_overflow", 32'(evt_overflow), 32'h0);
    input_pins = 8'h01;
    repeat (8) tick();
    check("ovf_data", 32'(evt_data), 32'h04);
    check("ovf_flag", 32'(evt_overflow), 32'h1);
    check("ovf_irq", 32'(irq), 32'h1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("ovf_ack_valid", 32'(evt_valid), 32'h0);
    check("ovf_ack_flag", 32'(evt_overflow), 32'h0);
    check("ovf_ack_irq", 32'(irq), 32'h0);

    // Bit0 pending; bit3 event lands on the acknowledge edge and survives.
    rise_en = 8'h08;
    fall_en = 8'h01;
    input_pins = 8'h00;
    repeat (8) tick();
    check("hs_pend0", 32'(evt_data), 32'h01);
    fall_en = 8'h00;
    tick();
    check("en_change_keeps", 32'(evt_data), 32'h01);
    input_pins = 8'h08;
    tick();
    repeat (4) tick();
    check("hs_pre_data", 32'(evt_data), 32'h01);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("hs_new_wins_data", 32'(evt_data), 32'h08);
    check("hs_new_wins_valid", 32'(evt_valid), 32'h1);
    check("hs_new_wins_ovf", 32'(evt_overflow), 32'h0);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;

    // Asynchronous reset mid-debounce with 8'h03 pending.
    rise_en = 8'h03;
    fall_en = 8'h00;
    input_pins = 8'h0B;
    repeat (8) tick();
    check("ar_pend", 32'(evt_data), 32'h03);
    input_pins = 8'h0F;
    repeat (3) tick();
    #1;
    rst = 1'b1;
    #1;
    check("ar_pins", 32'(pins_out), 32'h00);
    check("ar_valid", 32'(evt_valid), 32'h0);
    check("ar_data", 32'(evt_data), 32'h00);
    check("ar_irq", 32'(irq), 32'h0);
    input_pins = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    rise_en = 8'hFF;
    fall_en = 8'hFF;
    repeat (10) tick();
    check("ar_post_pins", 32'(pins_out), 32'h00);
    check("ar_post_valid", 32'(evt_valid), 32'h0);
    check("ar_post_ovf", 32'(evt_overflow), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
